// File: rtl/axis_pkg.sv
// axis_pkg: shared stream sample types and the multiplier-arbiter issue tag
package axis_pkg;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } sample_t_int;
  localparam int N_MAX = 8;
  localparam int ID_W = $clog2(N_MAX);
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } cmult_tag_t;
endpackage

// File: rtl/cmult_res_fifo.sv
// cmult_res_fifo: synchronous result FIFO; overflow is excluded upstream by credits
module cmult_res_fifo
  import axis_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  sample_t_int din,
  output logic        empty,
  output sample_t_int head
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  sample_t_int mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  assign empty = count == '0;
  assign head  = mem[rp];
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= (int'(wp) == DEPTH - 1) ? '0 : wp + 1'b1;
      if (pop) rp <= (int'(rp) == DEPTH - 1) ? '0 : rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == CW'(DEPTH)));
endmodule

// File: rtl/cmult_arbiter.sv
// cmult_arbiter: round-robin sharing of one complex multiplier; define CMULT_ARB_STATS_EN for grant/stall counters
module cmult_arbiter
  import axis_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MULT_LAT   = 10,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        in_valid,
  output logic [N_REQ-1:0]        in_ready,
  input  sample_t_int [N_REQ-1:0] in_a,
  input  sample_t_int [N_REQ-1:0] in_b,
  output logic [N_REQ-1:0]        out_valid,
  input  logic [N_REQ-1:0]        out_ready,
  output sample_t_int [N_REQ-1:0] out_z,
  output sample_t_int             mult_a,
  output sample_t_int             mult_b,
  input  sample_t_int             mult_z,
  output logic                    busy
`ifdef CMULT_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][31:0]  grant_cnt,
  output logic [N_REQ-1:0][31:0]  stall_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(N_REQ);
  // one stage for the mult_a/b register, one for the multiplier's input register, then its pipeline
  localparam int TD = MULT_LAT + 2;
  logic [CW-1:0] credit [N_REQ];
  logic [PW-1:0] ptr, gnt, idx;
  logic [N_REQ-1:0] elig, nz, empty, push, pop;
  logic hit;
  cmult_tag_t tag_q [TD];
  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign nz[i]   = credit[i] != '0;
    assign push[i] = tag_q[TD-1].vld && tag_q[TD-1].id == ID_W'(i);
    cmult_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[i]),
      .pop  (pop[i]),
      .din  (mult_z),
      .empty(empty[i]),
      .head (out_z[i])
    );
  end
  assign elig      = rst ? '0 : in_valid & nz;
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign in_ready  = hit ? N_REQ'(1) << gnt : '0;
  always_comb begin
    hit = 1'b0;
    gnt = '0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!hit && elig[idx]) begin
        hit = 1'b1;
        gnt = idx;
      end
    end
  end
  always_comb begin
    busy = |out_valid;
    for (int k = 0; k < TD; k++) busy = busy | tag_q[k].vld;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      mult_a <= '0;
      mult_b <= '0;
      for (int i = 0; i < N_REQ; i++) credit[i] <= CW'(FIFO_DEPTH);
      for (int k = 0; k < TD; k++) tag_q[k] <= '0;
    end else begin
      if (hit) begin
        ptr    <= (int'(gnt) == N_REQ - 1) ? '0 : gnt + 1'b1;
        mult_a <= in_a[gnt];
        mult_b <= in_b[gnt];
      end
      tag_q[0] <= '{vld: hit, id: ID_W'(gnt)};
      for (int k = 1; k < TD; k++) tag_q[k] <= tag_q[k-1];
      for (int i = 0; i < N_REQ; i++) credit[i] <= credit[i] - CW'(in_ready[i]) + CW'(pop[i]);
    end
  end
`ifdef CMULT_ARB_STATS_EN
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++) begin
      grant_cnt[i] <= rst ? '0 : grant_cnt[i] + 32'(in_ready[i]);
      stall_cnt[i] <= rst ? '0 : stall_cnt[i] + 32'(in_valid[i] && !in_ready[i]);
    end
  end
`endif
endmodule
